shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Sequencer that loads a parallel word into the team's serial-in shift register (ports data_in/en/dir/sreg).
- Accepts one word per request over a valid/ready handshake.
- Drives the register's serial input, enable and direction for exactly WIDTH shift cycles, waits one settle cycle, then returns the register's parallel contents over a valid/ready result handshake.
- Sits between a host/config block and a single shift register instance. It is the only driver of that register's control inputs.

Parameters:
- WIDTH, 5, shift register length in bits. Legal range is 2 to 32.
- CNT_W, $clog2(WIDTH+1), shift counter width. Derived; must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request word present
- req_ready  out  1  controller can accept a request
- req_data  in  WIDTH  word to load
- req_dir  in  1  0 = shift-left mode, 1 = shift-right mode
- abort  in  1  cancel the operation in progress
- sr_data_in  out  1  serial bit to the shift register
- sr_en  out  1  shift enable to the shift register
- sr_dir  out  1  direction to the shift register
- sr_sreg  in  WIDTH  parallel contents of the shift register
- done_valid  out  1  result word present
- done_ready  in  1  consumer accepts the result
- done_data  out  WIDTH  captured sr_sreg
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset values: state=IDLE, req_ready=1, sr_data_in=0, sr_en=0, sr_dir=0, done_valid=0, done_data=0, busy=0, counter=0.
- The shift register samples data_in/en/dir on the rising edge.
  - dir=0: shifts left, and data_in enters bit 0.
  - dir=1: shifts right, and data_in enters bit WIDTH-1.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T: latch req_data and req_dir, clear the counter, go to SHIFT.
- SHIFT (cycles T+1 .. T+WIDTH):
  - sr_en=1 and sr_dir=latched dir.
  - Bit order on sr_data_in:
    - dir=0: MSB first (req_data[WIDTH-1] down to [0]).
    - dir=1: LSB first ([0] up to [WIDTH-1]).
  - The counter increments each cycle. After WIDTH cycles, go to SETTLE.
- SETTLE (cycle T+WIDTH+1):
  - sr_en=0.
  - At the end of the cycle, capture sr_sreg into done_data, set done_valid=1, go to DONE.
  - With a correct shift register, done_data equals the latched word in both directions.
- DONE:
  - Hold done_valid and done_data stable until done_valid&&done_ready.
  - Then clear done_valid and go to IDLE.
  - A new request is accepted on the cycle after the result handshake.
- Latency:
  - Request handshake to done_valid = WIDTH+2 cycles.
  - Minimum request-to-request spacing = WIDTH+3 cycles.
- req_ready=1 only in IDLE. Requests presented in other states are stalled, not dropped.
- sr_en is never high outside SHIFT. sr_dir is stable for the entire SHIFT phase.
- abort:
  - In SHIFT or SETTLE: go to IDLE at the next edge, sr_en=0, no result produced, shift register contents left partial.
  - In DONE: drop done_valid and go to IDLE.
  - In IDLE: no effect.
- Simultaneous events:
  - abort and done_ready in DONE: treated as abort (same end state).
  - rst overrides abort and all handshakes.
- rst mid-operation: all state and outputs return to reset values at the next edge. The in-flight word is discarded.

Optional Feature:
- Macro: SHIFT_SEQ_CHECK_EN.
- When defined:
  - Adds an output err (1 bit).
  - In SETTLE, compare sr_sreg against the latched word. On mismatch, set err=1 together with done_valid.
  - err clears on the result handshake, on abort, or on rst.
- When undefined: no err port and no comparator. Behaviour is otherwise identical.

Decomposition:
- Shared package shift_seq_pkg holds:
  - state encoding enum: IDLE=2'd0, SHIFT=2'd1, SETTLE=2'd2, DONE=2'd3
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1
- One natural sub-module, shift_seq_bitsel: the combinational bit-index select (count → bit position by dir). Keep it inline if it is small.
- The team's shift register is instantiated only in the testbench, not inside this block.

Test Plan:
- Reset: rst=1 for 2 cycles → req_ready=1, busy=0, sr_en=0, done_valid=0, done_data=5'b00000.
- Left load: req_data=5'b10110, req_dir=0, done_ready=1 → sr_data_in=1,0,1,1,0 over 5 cycles with sr_en=1, sr_dir=0; done_valid 7 cycles after accept with done_data=5'b10110.
- Right load: req_data=5'b10110, req_dir=1 → sr_data_in=0,1,1,0,1; done_data=5'b10110; sr_dir=1 throughout SHIFT.
- Backpressure: done_ready=0 for 10 cycles → done_valid and done_data stable, req_ready=0; a request held during this time is accepted the cycle after done_ready rises.
- Abort: abort pulsed on the 3rd SHIFT cycle → next cycle IDLE, sr_en=0, no done_valid; a following request 5'b01001 completes correctly.
- Reset mid-shift: rst at the 2nd SHIFT cycle → all outputs at reset values next edge. With SHIFT_SEQ_CHECK_EN defined, a bench-forced sr_sreg=5'b00000 for word 5'b11111 → err=1 with done_valid.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register load sequencer.
//   state_e   : controller state encoding
//   DIR_LEFT  : shift-left mode (serial bit enters bit 0, word sent MSB first)
//   DIR_RIGHT : shift-right mode (serial bit enters bit WIDTH-1, word sent LSB first)
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_bitsel.sv
// Combinational serial-bit select for the sequencer.
// Maps the number of bits already sent to the word bit that goes out next:
// left mode walks MSB->LSB, right mode walks LSB->MSB.
// Ports:
//   word_i : word being serialised
//   dir_i  : DIR_LEFT / DIR_RIGHT
//   cnt_i  : bits already sent (0..WIDTH); WIDTH and above yields 0
//   bit_o  : serial bit for this count
module shift_seq_bitsel
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic             dir_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             bit_o
);

    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        idx     = (dir_i == DIR_RIGHT) ? cnt_i : (CNT_W'(WIDTH - 1) - cnt_i);
        shifted = word_i >> idx;
        bit_o   = (cnt_i < CNT_W'(WIDTH)) ? shifted[0] : 1'b0;
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that loads a parallel word into an external serial-in shift
// register, then returns the register's parallel contents.
// Build option: define SHIFT_SEQ_CHECK_EN to add the err output, which flags
// a readback that differs from the word that was loaded.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   req_valid/ready/data : request handshake carrying the word to load
//   req_dir              : 0 = shift-left mode, 1 = shift-right mode
//   abort                : cancel the operation in progress
//   sr_data_in/en/dir    : control inputs of the shift register
//   sr_sreg              : parallel contents of the shift register
//   done_valid/ready/data: result handshake carrying the captured contents
//   busy                 : high whenever the controller is not idle
//   err (optional)       : readback mismatch, valid alongside done_valid
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic             abort,
    output logic             sr_data_in,
    output logic             sr_en,
    output logic             sr_dir,
    input  logic [WIDTH-1:0] sr_sreg,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] done_data,
    output logic             busy
`ifdef SHIFT_SEQ_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;
    logic             req_ready_q, req_ready_d;
    logic             sr_data_in_q, sr_data_in_d;
    logic             sr_en_q, sr_en_d;
    logic             sr_dir_q, sr_dir_d;
    logic             done_valid_q, done_valid_d;
    logic [WIDTH-1:0] done_data_q, done_data_d;
    logic             busy_q, busy_d;
`ifdef SHIFT_SEQ_CHECK_EN
    logic             err_q, err_d;
`endif

    // Outputs are registered, so the bit driven during a SHIFT cycle is
    // selected one edge early using the count that cycle will hold. On the
    // accepting edge the word is not latched yet, so select from the request.
    logic [WIDTH-1:0] sel_word;
    logic             sel_dir;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_bit;

    assign sel_word = (state_q == IDLE) ? req_data : word_q;
    assign sel_dir  = (state_q == IDLE) ? req_dir  : dir_q;
    assign sel_cnt  = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);

    shift_seq_bitsel #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitsel (
        .word_i (sel_word),
        .dir_i  (sel_dir),
        .cnt_i  (sel_cnt),
        .bit_o  (sel_bit)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        dir_d        = dir_q;
        sr_data_in_d = 1'b0;
        sr_en_d      = 1'b0;
        sr_dir_d     = sr_dir_q;
        done_valid_d = done_valid_q;
        done_data_d  = done_data_q;
`ifdef SHIFT_SEQ_CHECK_EN
        err_d        = err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    word_d       = req_data;
                    dir_d        = req_dir;
                    cnt_d        = '0;
                    state_d      = SHIFT;
                    sr_en_d      = 1'b1;
                    sr_dir_d     = req_dir;
                    sr_data_in_d = sel_bit;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = sel_cnt;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = SETTLE;
                    end else begin
                        sr_en_d      = 1'b1;
                        sr_data_in_d = sel_bit;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    done_data_d  = sr_sreg;
                    done_valid_d = 1'b1;
                    state_d      = DONE;
`ifdef SHIFT_SEQ_CHECK_EN
                    err_d        = (sr_sreg != word_q);
`endif
                end
            end
            DONE: begin
                // abort and the result handshake share the same exit
                if (abort || done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
`ifdef SHIFT_SEQ_CHECK_EN
                    err_d        = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            dir_q        <= DIR_LEFT;
            req_ready_q  <= 1'b1;
            sr_data_in_q <= 1'b0;
            sr_en_q      <= 1'b0;
            sr_dir_q     <= DIR_LEFT;
            done_valid_q <= 1'b0;
            done_data_q  <= '0;
            busy_q       <= 1'b0;
`ifdef SHIFT_SEQ_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            dir_q        <= dir_d;
            req_ready_q  <= req_ready_d;
            sr_data_in_q <= sr_data_in_d;
            sr_en_q      <= sr_en_d;
            sr_dir_q     <= sr_dir_d;
            done_valid_q <= done_valid_d;
            done_data_q  <= done_data_d;
            busy_q       <= busy_d;
`ifdef SHIFT_SEQ_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign sr_data_in = sr_data_in_q;
    assign sr_en      = sr_en_q;
    assign sr_dir     = sr_dir_q;
    assign done_valid = done_valid_q;
    assign done_data  = done_data_q;
    assign busy       = busy_q;
`ifdef SHIFT_SEQ_CHECK_EN
    assign err        = err_q;
`endif

endmodule
